// File: rtl/mips_bus_ctrl_if.sv
// rtl/mips_bus_ctrl_if.sv - Avalon-MM master port bundle for the MIPS bus bridge
interface mips_bus_ctrl_if;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic        waitrequest;
  logic [31:0] readdata;
  logic [31:0] writedata;
  logic [3:0]  byteenable;

  modport master (
    output address, read, write, writedata, byteenable,
    input  waitrequest, readdata
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output waitrequest, readdata
  );
endinterface

// File: rtl/mips_bus_ctrl.sv
// rtl/mips_bus_ctrl.sv - merges fetch and load/store onto one Avalon-MM master
// with waitrequest handling, timeout abort and load alignment/extension.
module mips_bus_ctrl #(
  parameter int WAIT_TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   fetch_req,
  input  logic [31:0]            fetch_addr,
  output logic                   fetch_ready,
  output logic [31:0]            fetch_instr,
  output logic                   fetch_error,
  input  logic                   mem_req,
  input  logic                   mem_we,
  input  logic [1:0]             mem_size,
  input  logic                   mem_signed,
  input  logic [31:0]            mem_addr,
  input  logic [31:0]            mem_wdata,
  output logic                   mem_ready,
  output logic [31:0]            mem_rdata,
  output logic                   mem_error,
  output logic                   busy,
  mips_bus_ctrl_if.master        bus
);

  typedef enum logic [1:0] {IDLE, BUS_DATA, BUS_FETCH, RESP} state_t;

  localparam logic [15:0] TIMEOUT = 16'(WAIT_TIMEOUT);

  state_t      state_q, state_d;
  logic [31:0] address_q, address_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic        read_q, read_d;
  logic        write_q, write_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  off_q, off_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic        fetch_q, fetch_d;
  logic        err_q, err_d;
  logic [31:0] data_q, data_d;

  logic        mem_mis;
  logic        fetch_mis;
  logic [31:0] lane;
  logic [31:0] load_ext;
  logic [15:0] cnt_inc;

  always_comb begin
    mem_mis   = (mem_size == 2'b11) ||
                (mem_size == 2'b10 && mem_addr[1:0] != 2'b00) ||
                (mem_size == 2'b01 && mem_addr[0]);
    fetch_mis = (fetch_addr[1:0] != 2'b00);
    lane      = bus.readdata >> {off_q, 3'b000};
    cnt_inc   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    case (size_q)
      2'b00:   load_ext = signed_q ? {{24{lane[7]}}, lane[7:0]} : {24'h0, lane[7:0]};
      2'b01:   load_ext = signed_q ? {{16{lane[15]}}, lane[15:0]} : {16'h0, lane[15:0]};
      default: load_ext = lane;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    address_d = address_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    read_d    = read_q;
    write_d   = write_q;
    cnt_d     = cnt_q;
    off_d     = off_q;
    size_d    = size_q;
    signed_d  = signed_q;
    fetch_d   = fetch_q;
    err_d     = err_q;
    data_d    = data_q;

    case (state_q)
      IDLE: begin
        // Data accesses win; a pending fetch simply stays requested until next IDLE.
        if (mem_req) begin
          fetch_d  = 1'b0;
          off_d    = mem_addr[1:0];
          size_d   = mem_size;
          signed_d = mem_signed;
          err_d    = mem_mis;
          data_d   = 32'h0;
          if (mem_mis) begin
            state_d = RESP;
          end else begin
            state_d   = BUS_DATA;
            address_d = {mem_addr[31:2], 2'b00};
            read_d    = !mem_we;
            write_d   = mem_we;
            cnt_d     = 16'h0;
            case (mem_size)
              2'b00: begin
                be_d    = 4'b0001 << mem_addr[1:0];
                wdata_d = {4{mem_wdata[7:0]}};
              end
              2'b01: begin
                be_d    = mem_addr[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{mem_wdata[15:0]}};
              end
              default: begin
                be_d    = 4'b1111;
                wdata_d = mem_wdata;
              end
            endcase
          end
        end else if (fetch_req) begin
          fetch_d  = 1'b1;
          off_d    = 2'b00;
          size_d   = 2'b10;
          signed_d = 1'b0;
          err_d    = fetch_mis;
          data_d   = 32'h0;
          if (fetch_mis) begin
            state_d = RESP;
          end else begin
            state_d   = BUS_FETCH;
            address_d = {fetch_addr[31:2], 2'b00};
            be_d      = 4'b1111;
            read_d    = 1'b1;
            write_d   = 1'b0;
            cnt_d     = 16'h0;
          end
        end
      end
      BUS_DATA, BUS_FETCH: begin
        if (!bus.waitrequest) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          state_d = RESP;
          if (state_q == BUS_FETCH) data_d = bus.readdata;
          else if (write_q)         data_d = 32'h0;
          else                      data_d = load_ext;
        end else begin
          cnt_d = cnt_inc;
          if (TIMEOUT != 16'h0 && cnt_inc == TIMEOUT) begin
            read_d  = 1'b0;
            write_d = 1'b0;
            err_d   = 1'b1;
            data_d  = 32'h0;
            state_d = RESP;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      address_q <= 32'h0;
      be_q      <= 4'h0;
      wdata_q   <= 32'h0;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      cnt_q     <= 16'h0;
      off_q     <= 2'b00;
      size_q    <= 2'b00;
      signed_q  <= 1'b0;
      fetch_q   <= 1'b0;
      err_q     <= 1'b0;
      data_q    <= 32'h0;
    end else begin
      state_q   <= state_d;
      address_q <= address_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      read_q    <= read_d;
      write_q   <= write_d;
      cnt_q     <= cnt_d;
      off_q     <= off_d;
      size_q    <= size_d;
      signed_q  <= signed_d;
      fetch_q   <= fetch_d;
      err_q     <= err_d;
      data_q    <= data_d;
    end
  end

  // Response outputs are gated so error/data read as zero outside the ready pulse.
  assign fetch_ready    = (state_q == RESP) && fetch_q;
  assign mem_ready      = (state_q == RESP) && !fetch_q;
  assign fetch_error    = fetch_ready && err_q;
  assign mem_error      = mem_ready && err_q;
  assign fetch_instr    = fetch_ready ? data_q : 32'h0;
  assign mem_rdata      = mem_ready ? data_q : 32'h0;
  assign busy           = (state_q != IDLE);

  assign bus.address    = address_q;
  assign bus.byteenable = be_q;
  assign bus.writedata  = wdata_q;
  assign bus.read       = read_q;
  assign bus.write      = write_q;

endmodule

// File: tb/tb_mips_bus_ctrl.sv
// tb/tb_mips_bus_ctrl.sv - directed scoreboard bench for mips_bus_ctrl
module tb_mips_bus_ctrl;

  logic        clk;
  logic        reset;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_ready;
  logic [31:0] fetch_instr;
  logic        fetch_error;
  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_size;
  logic        mem_signed;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        mem_error;
  logic        busy;

  mips_bus_ctrl_if bus ();

  mips_bus_ctrl #(.WAIT_TIMEOUT(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_ready (fetch_ready),
    .fetch_instr (fetch_instr),
    .fetch_error (fetch_error),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_size    (mem_size),
    .mem_signed  (mem_signed),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ready   (mem_ready),
    .mem_rdata   (mem_rdata),
    .mem_error   (mem_error),
    .busy        (busy),
    .bus         (bus)
  );

  typedef struct {
    bit          is_fetch;
    logic [31:0] data;
    logic        err;
    int          start;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_pass = 0;
  int          n_total = 0;
  int          n_ready = 0;
  int          cyc = 0;
  int          wait_n = 0;
  int          stb_n = 0;
  logic [31:0] rd_word = 32'h0;

  int          s_cnt;
  bit          s_rd;
  bit          s_wr;
  bit          s_stable;
  logic [31:0] s_addr;
  logic [31:0] s_wd;
  logic [3:0]  s_be;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
  endtask

  // Slave model: stalls the first wait_n strobe cycles of each transfer.
  always @(negedge clk) begin
    if (bus.read || bus.write) begin
      bus.waitrequest = (stb_n < wait_n);
      stb_n++;
    end else begin
      stb_n = 0;
      bus.waitrequest = 1'b0;
    end
    bus.readdata = rd_word;
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("addr_align", 32'(bus.address[1:0]), 32'h0);
      chk("rw_exclusive", 32'(bus.read && bus.write), 32'h0);
      if (fetch_ready || mem_ready) begin
        n_ready++;
        if (sb.size() == 0) begin
          chk("unexpected_ready", {30'h0, fetch_ready, mem_ready}, 32'h0);
        end else begin
          mon_e = sb.pop_front();
          chk("ready_port", 32'(fetch_ready), 32'(mon_e.is_fetch));
          chk("latency", 32'(cyc - mon_e.start), 32'(mon_e.lat));
          if (mon_e.is_fetch) begin
            chk("fetch_instr", fetch_instr, mon_e.data);
            chk("fetch_error", 32'(fetch_error), 32'(mon_e.err));
          end else begin
            chk("mem_rdata", mem_rdata, mon_e.data);
            chk("mem_error", 32'(mem_error), 32'(mon_e.err));
          end
        end
      end else if (fetch_error || mem_error) begin
        chk("error_outside_ready", {30'h0, fetch_error, mem_error}, 32'h0);
      end
    end
  end

  task automatic push(input bit f, input logic [31:0] d, input logic er, input int lat);
    exp_t x;
    x.is_fetch = f;
    x.data     = d;
    x.err      = er;
    x.start    = cyc;
    x.lat      = lat;
    sb.push_back(x);
  endtask

  task automatic wait_done();
    bit done;
    done = 1'b0;
    s_cnt = 0;
    s_stable = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (bus.read || bus.write) begin
        if (s_cnt == 0) begin
          s_rd = bus.read; s_wr = bus.write;
          s_addr = bus.address; s_wd = bus.writedata; s_be = bus.byteenable;
        end else if (s_rd !== bus.read || s_wr !== bus.write || s_addr !== bus.address ||
                     s_wd !== bus.writedata || s_be !== bus.byteenable) begin
          s_stable = 1'b0;
        end
        s_cnt++;
      end
      if (fetch_ready || mem_ready) done = 1'b1;
    end
    chk("ready_seen", 32'(done), 32'h1);
  endtask

  task automatic mem_op(input bit we, input logic [1:0] size, input bit sgn,
                        input logic [31:0] addr, input logic [31:0] wd, input int w,
                        input logic [31:0] rd, input logic [31:0] exp_d,
                        input bit exp_err, input int lat);
    @(posedge clk); #1;
    wait_n = w; rd_word = rd;
    mem_we = we; mem_size = size; mem_signed = sgn; mem_addr = addr; mem_wdata = wd;
    mem_req = 1'b1;
    push(1'b0, exp_d, exp_err, lat);
    wait_done();
    mem_req = 1'b0;
  endtask

  task automatic fetch_op(input logic [31:0] addr, input int w, input logic [31:0] rd,
                          input logic [31:0] exp_d, input bit exp_err, input int lat);
    @(posedge clk); #1;
    wait_n = w; rd_word = rd;
    fetch_addr = addr;
    fetch_req = 1'b1;
    push(1'b1, exp_d, exp_err, lat);
    wait_done();
    fetch_req = 1'b0;
  endtask

  initial begin
    int r0;
    reset = 1'b1;
    fetch_req = 1'b0; fetch_addr = 32'h0;
    mem_req = 1'b0; mem_we = 1'b0; mem_size = 2'b00; mem_signed = 1'b0;
    mem_addr = 32'h0; mem_wdata = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_address", bus.address, 32'h0);
    chk("rst_writedata", bus.writedata, 32'h0);
    chk("rst_be", 32'(bus.byteenable), 32'h0);
    chk("rst_flags", {25'h0, bus.read, bus.write, busy, fetch_ready, mem_ready,
                      fetch_error, mem_error}, 32'h0);
    chk("rst_data", fetch_instr | mem_rdata, 32'h0);
    @(posedge clk); #1 reset = 1'b0;

    fetch_op(32'hBFC00000, 0, 32'h24020005, 32'h24020005, 1'b0, 2);
    chk("t1_strobes", 32'(s_cnt), 32'd1);
    chk("t1_read", 32'(s_rd), 32'h1);
    chk("t1_be", 32'(s_be), 32'hF);
    chk("t1_addr", s_addr, 32'hBFC00000);

    mem_op(1'b0, 2'b00, 1'b1, 32'h00001003, 32'h0, 0, 32'h80FFFFFF, 32'hFFFFFF80, 1'b0, 2);
    chk("t2_addr", s_addr, 32'h00001000);
    chk("t2_be", 32'(s_be), 32'h8);
    mem_op(1'b0, 2'b00, 1'b0, 32'h00001003, 32'h0, 0, 32'h80FFFFFF, 32'h00000080, 1'b0, 2);
    mem_op(1'b0, 2'b01, 1'b1, 32'h00002002, 32'h0, 0, 32'hBEEF0000, 32'hFFFFBEEF, 1'b0, 2);
    chk("t2_lh_be", 32'(s_be), 32'hC);
    mem_op(1'b0, 2'b10, 1'b0, 32'h00004000, 32'h0, 1, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 3);

    mem_op(1'b1, 2'b01, 1'b0, 32'h00002002, 32'h00001234, 3, 32'hFFFFFFFF, 32'h0, 1'b0, 5);
    chk("t3_strobes", 32'(s_cnt), 32'd4);
    chk("t3_write", {30'h0, s_rd, s_wr}, 32'h1);
    chk("t3_wdata", s_wd, 32'h12341234);
    chk("t3_be", 32'(s_be), 32'hC);
    chk("t3_addr", s_addr, 32'h00002000);
    chk("t3_stable", 32'(s_stable), 32'h1);
    mem_op(1'b1, 2'b00, 1'b0, 32'h00001001, 32'h000000AB, 0, 32'h0, 32'h0, 1'b0, 2);
    chk("t3_sb_wdata", s_wd, 32'hABABABAB);
    chk("t3_sb_be", 32'(s_be), 32'h2);

    @(posedge clk); #1;
    wait_n = 0; rd_word = 32'h11112222;
    mem_we = 1'b0; mem_size = 2'b10; mem_signed = 1'b0; mem_addr = 32'h00005000;
    fetch_addr = 32'h00006000;
    mem_req = 1'b1; fetch_req = 1'b1;
    push(1'b0, 32'h11112222, 1'b0, 2);
    push(1'b1, 32'h11112222, 1'b0, 5);
    wait_done();
    mem_req = 1'b0;
    chk("t4_first_addr", s_addr, 32'h00005000);
    wait_done();
    fetch_req = 1'b0;
    chk("t4_second_addr", s_addr, 32'h00006000);

    mem_op(1'b0, 2'b10, 1'b0, 32'h00001001, 32'h0, 0, 32'h12345678, 32'h0, 1'b1, 1);
    chk("t5_mis_strobes", 32'(s_cnt), 32'd0);
    mem_op(1'b0, 2'b01, 1'b0, 32'h00001001, 32'h0, 0, 32'h12345678, 32'h0, 1'b1, 1);
    mem_op(1'b1, 2'b11, 1'b0, 32'h00001000, 32'h0, 0, 32'h12345678, 32'h0, 1'b1, 1);
    fetch_op(32'h00000002, 0, 32'h12345678, 32'h0, 1'b1, 1);
    chk("t5_fmis_strobes", 32'(s_cnt), 32'd0);
    mem_op(1'b0, 2'b10, 1'b0, 32'h00003000, 32'h0, 1000, 32'h12345678, 32'h0, 1'b1, 5);
    chk("t5_timeout_strobes", 32'(s_cnt), 32'd4);

    @(posedge clk); #1;
    wait_n = 1000; rd_word = 32'h55555555;
    mem_we = 1'b0; mem_size = 2'b10; mem_addr = 32'h00007000;
    mem_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t6_read_before", 32'(bus.read), 32'h1);
    reset = 1'b1; mem_req = 1'b0;
    @(negedge clk);
    chk("t6_read_after", {30'h0, bus.read, bus.write}, 32'h0);
    chk("t6_busy_after", 32'(busy), 32'h0);
    r0 = n_ready;
    @(posedge clk); #1 reset = 1'b0;
    repeat (6) @(negedge clk);
    chk("t6_no_ready", 32'(n_ready), 32'(r0));
    chk("sb_empty", 32'(sb.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
